// File: rtl/accum_alu_if.sv
// Accumulator ALU bus interface.
//   master : drives start, op, acc_en, a, b; observes status and results.
//   slave  : the ALU side; receives the request, drives busy, done, result,
//            accum, overflow, div_by_zero, zero, acc_ovf.
// N is the operand width; result and accum are 2N bits wide.
interface accum_alu_if #(parameter int N = 16);
    logic             start;
    logic [3:0]       op;
    logic             acc_en;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   result;
    logic [2*N-1:0]   accum;
    logic             overflow;
    logic             div_by_zero;
    logic             zero;
    logic             acc_ovf;

    modport master (
        output start, op, acc_en, a, b,
        input  busy, done, result, accum, overflow, div_by_zero, zero, acc_ovf
    );

    modport slave (
        input  start, op, acc_en, a, b,
        output busy, done, result, accum, overflow, div_by_zero, zero, acc_ovf
    );
endinterface

// File: rtl/accum_alu.sv
// Accumulating ALU with iterative multiply and divide.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : accum_alu_if slave port
//         start/op/acc_en/a/b are captured on the edge where start=1, busy=0.
//         busy is high while MUL/DIV iterate; done pulses for one cycle when
//         result, flags and accum take their new values.
// Single-cycle ops finish on the accepting edge; MUL/DIV run N iterations
// and finish N edges later. DIV by zero finishes immediately.
module accum_alu #(
    parameter int N = 16
) (
    input  logic  clk,
    input  logic  rst,
    accum_alu_if.slave bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(N);

    localparam logic [3:0] OP_NOP  = 4'd0,  OP_ADD  = 4'd1,  OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3,  OP_DIV  = 4'd4,  OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6,  OP_AND  = 4'd7,  OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9,  OP_NOT  = 4'd10, OP_NAND = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12, OP_XNOR = 4'd13, OP_CLR  = 4'd14;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t state, state_next;

    logic [3:0]    op_q;
    logic          acc_en_q;
    logic [W-1:0]  mcand;
    logic [N-1:0]  mplier;
    logic [W-1:0]  prod;
    logic [N:0]    rem;
    logic [N-1:0]  quo;
    logic [N-1:0]  dvs;
    logic [CW-1:0] cnt;

    logic [W-1:0]  result_q, accum_q;
    logic          ovf_q, dbz_q, zero_q, acc_ovf_q;

    logic          accept, is_iter, iter_last, finish;
    logic [W-1:0]  a_ext, b_ext;
    logic [N:0]    add_sum;
    logic [W-1:0]  prod_next;
    logic [N:0]    rem_shift, rem_next;
    logic [N-1:0]  quo_next;
    logic [W-1:0]  single_res;
    logic          single_ovf, single_dbz;
    logic [W-1:0]  fin_res;
    logic          fin_ovf, fin_dbz, fin_acc_en, fin_clr;
    logic [W:0]    acc_sum;

    assign accept    = (state != ITER) && bus.start;
    assign is_iter   = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != '0));
    assign iter_last = (state == ITER) && (cnt == CW'(N - 1));
    assign finish    = (accept && !is_iter) || iter_last;

    // Next-state logic; DONE behaves like IDLE so a new request can be taken
    // in the same cycle that done is high.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept) state_next = is_iter ? ITER : DONE;
            end
            ITER: if (iter_last) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // One shift-add step and one restoring-division step; the final step's
    // output is used directly as the result on the finishing edge.
    always_comb begin
        prod_next = prod + (mplier[0] ? mcand : '0);
        rem_shift = {rem[N-1:0], quo[N-1]};
        if (rem_shift >= {1'b0, dvs}) begin
            rem_next = rem_shift - {1'b0, dvs};
            quo_next = {quo[N-2:0], 1'b1};
        end else begin
            rem_next = rem_shift;
            quo_next = {quo[N-2:0], 1'b0};
        end
    end

    // Results of ops that complete on the accepting edge, taken straight
    // from the bus inputs.
    always_comb begin
        a_ext      = {{N{1'b0}}, bus.a};
        b_ext      = {{N{1'b0}}, bus.b};
        add_sum    = {1'b0, bus.a} + {1'b0, bus.b};
        single_res = '0;
        single_ovf = 1'b0;
        single_dbz = 1'b0;
        case (bus.op)
            OP_ADD: begin
                single_res = {{(N-1){1'b0}}, add_sum};
                single_ovf = add_sum[N];
            end
            OP_SUB: begin
                single_res = a_ext - b_ext;
                single_ovf = bus.a < bus.b;
            end
            OP_DIV: begin
                single_res = {bus.a, {N{1'b1}}};
                single_dbz = 1'b1;
            end
            OP_SLL:  single_res = a_ext << bus.b;
            OP_SRL:  single_res = a_ext >> bus.b;
            OP_AND:  single_res = {{N{1'b0}}, bus.a & bus.b};
            OP_OR:   single_res = {{N{1'b0}}, bus.a | bus.b};
            OP_XOR:  single_res = {{N{1'b0}}, bus.a ^ bus.b};
            OP_NOT:  single_res = {{N{1'b0}}, ~bus.a};
            OP_NAND: single_res = {{N{1'b0}}, ~(bus.a & bus.b)};
            OP_NOR:  single_res = {{N{1'b0}}, ~(bus.a | bus.b)};
            OP_XNOR: single_res = {{N{1'b0}}, ~(bus.a ^ bus.b)};
            default: single_res = '0;
        endcase
    end

    // Select what gets written on a finishing edge.
    always_comb begin
        if (iter_last) begin
            fin_res    = (op_q == OP_MUL) ? prod_next : {rem_next[N-1:0], quo_next};
            fin_ovf    = (op_q == OP_MUL) ? |prod_next[W-1:N] : 1'b0;
            fin_dbz    = 1'b0;
            fin_acc_en = acc_en_q;
            fin_clr    = 1'b0;
        end else begin
            fin_res    = single_res;
            fin_ovf    = single_ovf;
            fin_dbz    = single_dbz;
            fin_acc_en = bus.acc_en && (bus.op != OP_CLR);
            fin_clr    = (bus.op == OP_CLR);
        end
        acc_sum = {1'b0, accum_q} + {1'b0, fin_res};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= '0;
            acc_en_q  <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            result_q  <= '0;
            accum_q   <= '0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
            zero_q    <= 1'b0;
            acc_ovf_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q     <= bus.op;
                acc_en_q <= bus.acc_en;
                mcand    <= a_ext;
                mplier   <= bus.b;
                prod     <= '0;
                rem      <= '0;
                quo      <= bus.a;
                dvs      <= bus.b;
                cnt      <= '0;
            end else if (state == ITER) begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                prod   <= prod_next;
                rem    <= rem_next;
                quo    <= quo_next;
                cnt    <= cnt + 1'b1;
            end
            if (finish) begin
                result_q <= fin_res;
                ovf_q    <= fin_ovf;
                dbz_q    <= fin_dbz;
                zero_q   <= (fin_res == '0);
                if (fin_clr) begin
                    accum_q   <= '0;
                    acc_ovf_q <= 1'b0;
                end else if (fin_acc_en) begin
                    accum_q <= acc_sum[W-1:0];
                    if (acc_sum[W]) acc_ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy        = (state == ITER);
    assign bus.done        = (state == DONE);
    assign bus.result      = result_q;
    assign bus.accum       = accum_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.zero        = zero_q;
    assign bus.acc_ovf     = acc_ovf_q;
endmodule

// File: tb/tb_accum_alu.sv
// Testbench for accum_alu (N=16): directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a
// behavioural reference model.
module tb_accum_alu;
    localparam int N = 16;
    localparam longint unsigned MASKN = 64'h0000_0000_0000_FFFF;
    localparam longint unsigned MASKW = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    accum_alu_if #(.N(N)) bus();

    accum_alu #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int passes = 0;
    bit check_en = 1'b0;

    // Reference model state: observable outputs plus the pending request.
    bit              m_busy = 0, m_done = 0;
    int              m_left = 0;
    logic [31:0]     m_result = '0, m_accum = '0;
    bit              m_ovf = 0, m_dbz = 0, m_zero = 0, m_accovf = 0;
    int              p_op = 0;
    longint unsigned p_a = 0, p_b = 0;
    bit              p_acc = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, actual, expected);
    endtask

    // Apply the finished pending op to the model outputs.
    task automatic finishOp();
        longint unsigned a = p_a, b = p_b, r = 0, s;
        bit ovf = 0, dbz = 0;
        case (p_op)
            1: begin r = a + b; ovf = (r > MASKN); end
            2: begin r = (a - b) & MASKW; ovf = (a < b); end
            3: begin r = a * b; ovf = ((r >> N) != 0); end
            4: if (b == 0) begin r = (a << N) | MASKN; dbz = 1; end
               else r = ((a % b) << N) | (a / b);
            5: r = (b >= 32) ? 0 : ((a << b) & MASKW);
            6: r = (b >= 32) ? 0 : (a >> b);
            7: r = a & b;
            8: r = a | b;
            9: r = a ^ b;
            10: r = ~a & MASKN;
            11: r = ~(a & b) & MASKN;
            12: r = ~(a | b) & MASKN;
            13: r = ~(a ^ b) & MASKN;
            default: r = 0;
        endcase
        m_result = r[31:0];
        m_ovf = ovf;
        m_dbz = dbz;
        m_zero = (r == 0);
        if (p_op == 14) begin
            m_accum = '0;
            m_accovf = 0;
        end else if (p_acc) begin
            s = longint'(m_accum) + r;
            m_accum = s[31:0];
            if (s > MASKW) m_accovf = 1;
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_done = 0; m_left = 0;
            m_result = '0; m_accum = '0;
            m_ovf = 0; m_dbz = 0; m_zero = 0; m_accovf = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    finishOp();
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (bus.start) begin
                p_op = int'(bus.op);
                p_a = longint'(bus.a);
                p_b = longint'(bus.b);
                p_acc = bus.acc_en;
                if (p_op == 3 || (p_op == 4 && p_b != 0)) begin
                    m_busy = 1;
                    m_left = N;
                end else begin
                    finishOp();
                    m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("busy", bus.busy, m_busy);
            checkOutput("done", bus.done, m_done);
            checkOutput("result", bus.result, m_result);
            checkOutput("accum", bus.accum, m_accum);
            checkOutput("overflow", bus.overflow, m_ovf);
            checkOutput("div_by_zero", bus.div_by_zero, m_dbz);
            checkOutput("zero", bus.zero, m_zero);
            checkOutput("acc_ovf", bus.acc_ovf, m_accovf);
        end
    end

    // Drive one request for one edge; returns at the negedge of cycle 1.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic acc_en);
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.acc_en = acc_en;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int first, input int limit, output int cycles);
        cycles = first;
        while (bus.done !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("done_within_limit", bus.done, 1'b1);
    endtask

    initial begin
        int cyc;
        int seen;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.acc_en = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", bus.busy, 1'b0);
        checkOutput("reset_result", bus.result, 32'h0);
        checkOutput("reset_accum", bus.accum, 32'h0);
        rst = 1'b1;

        applyStimulus(4'd1, 16'd17, 16'd15, 1'b0);
        checkOutput("add_done_c1", bus.done, 1'b1);
        checkOutput("add_result", bus.result, 32'h20);
        checkOutput("add_ovf", bus.overflow, 1'b0);
        checkOutput("add_zero", bus.zero, 1'b0);
        checkOutput("model_add", m_result, 32'h20);

        applyStimulus(4'd1, 16'hFFFF, 16'd1, 1'b0);
        checkOutput("addc_result", bus.result, 32'h0001_0000);
        checkOutput("addc_ovf", bus.overflow, 1'b1);

        applyStimulus(4'd2, 16'd3, 16'd5, 1'b0);
        checkOutput("sub_result", bus.result, 32'hFFFF_FFFE);
        checkOutput("sub_ovf", bus.overflow, 1'b1);
        checkOutput("model_sub", m_result, 32'hFFFF_FFFE);

        applyStimulus(4'd3, 16'd300, 16'd500, 1'b0);
        checkOutput("mul_busy_c1", bus.busy, 1'b1);
        bus.op = 4'd1; bus.a = 16'd1; bus.b = 16'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(2, 40, cyc);
        checkOutput("mul_latency", cyc, 17);
        checkOutput("mul_result", bus.result, 32'h0002_49F0);
        checkOutput("mul_ovf", bus.overflow, 1'b1);
        checkOutput("model_mul", m_result, 32'h0002_49F0);

        applyStimulus(4'd4, 16'd100, 16'd7, 1'b0);
        waitDone(1, 40, cyc);
        checkOutput("div_latency", cyc, 17);
        checkOutput("div_result", bus.result, 32'h0002_000E);
        checkOutput("model_div", m_result, 32'h0002_000E);

        applyStimulus(4'd4, 16'h1234, 16'd0, 1'b0);
        checkOutput("div0_done_c1", bus.done, 1'b1);
        checkOutput("div0_result", bus.result, 32'h1234_FFFF);
        checkOutput("div0_flag", bus.div_by_zero, 1'b1);

        // Three back-to-back accumulating ADDs with start held high.
        @(negedge clk);
        bus.op = 4'd1; bus.a = 16'd1; bus.b = 16'd1; bus.acc_en = 1'b1; bus.start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput("b2b_done", bus.done, 1'b1);
            checkOutput("b2b_accum", bus.accum, 32'(2 * k));
        end
        bus.start = 1'b0;
        applyStimulus(4'd14, 16'd9, 16'd9, 1'b1);
        checkOutput("clr_accum", bus.accum, 32'h0);
        checkOutput("clr_zero", bus.zero, 1'b1);

        applyStimulus(4'd1, 16'd5, 16'd6, 1'b1);
        checkOutput("pre_rst_accum", bus.accum, 32'd11);

        // Reset in the middle of a multiply, with start asserted alongside.
        applyStimulus(4'd3, 16'd300, 16'd500, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        bus.op = 4'd1; bus.a = 16'd7; bus.b = 16'd8; bus.acc_en = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", bus.busy, 1'b0);
        checkOutput("rst_done", bus.done, 1'b0);
        checkOutput("rst_result", bus.result, 32'h0);
        checkOutput("rst_accum", bus.accum, 32'h0);
        @(negedge clk);
        checkOutput("rst_priority_done", bus.done, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_done", bus.done, 1'b1);
        checkOutput("post_rst_result", bus.result, 32'd15);
        bus.start = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        checkOutput("no_late_done", seen, 0);

        // Randomized traffic, checked every cycle by the model compare.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 149) != 0);
            bus.start = ($urandom_range(0, 9) < 7);
            bus.op = 4'($urandom_range(0, 14));
            bus.acc_en = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: bus.a = 16'hFFFF;
                1: bus.a = 16'($urandom_range(0, 20));
                default: bus.a = 16'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: bus.b = 16'd0;
                1: bus.b = 16'($urandom_range(0, 40));
                2: bus.b = 16'hFFFF - 16'($urandom_range(0, 3));
                default: bus.b = 16'($urandom);
            endcase
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
